// File: rtl/mux16x1_struct.sv
// mux16x1_struct -- 16:1 lane selector built from five mux4x1 instances
// (four first-level muxes, one second-level mux), with a registered copy
// of the result and select for downstream consumers.
//
// Parameters:
//   WIDTH   bits per input lane
// Ports:
//   clk     rising-edge clock for the registered stage
//   rst     asynchronous active-high reset of the registered stage
//   in      16 lanes, lane k = in[k*WIDTH +: WIDTH]
//   sel     lane select 0..15
//   y       combinational selected lane (zero latency)
//   y_q     y registered (1 cycle)
//   sel_q   sel registered, aligned with y_q
//   vld_q   low in/after reset, high from first edge after reset release
//   sel_oh  (only with MUX16_ONEHOT_SEL_EN) one-hot decode of sel_q,
//           all zeros while vld_q is low
//
// Build option: define MUX16_ONEHOT_SEL_EN to add the sel_oh output.

module mux4x1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = d0;
    case (s)
      2'd0:    out = d0;
      2'd1:    out = d1;
      2'd2:    out = d2;
      default: out = d3;
    endcase
  end

endmodule

module mux16x1_struct #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*WIDTH-1:0]  in,
  input  logic [3:0]           sel,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     y_q,
  output logic [3:0]           sel_q,
  output logic                 vld_q
`ifdef MUX16_ONEHOT_SEL_EN
  ,
  output logic [15:0]          sel_oh
`endif
);

  logic [WIDTH-1:0] l1 [4];

  // Level 1: instance j handles lanes 4j..4j+3 using sel[1:0].
  for (genvar j = 0; j < 4; j++) begin : g_lvl1
    mux4x1 #(.WIDTH(WIDTH)) u_mux (
      .d0  (in[(4*j+0)*WIDTH +: WIDTH]),
      .d1  (in[(4*j+1)*WIDTH +: WIDTH]),
      .d2  (in[(4*j+2)*WIDTH +: WIDTH]),
      .d3  (in[(4*j+3)*WIDTH +: WIDTH]),
      .s   (sel[1:0]),
      .out (l1[j])
    );
  end

  // Level 2: picks one of the four level-1 results using sel[3:2].
  mux4x1 #(.WIDTH(WIDTH)) u_mux_l2 (
    .d0  (l1[0]),
    .d1  (l1[1]),
    .d2  (l1[2]),
    .d3  (l1[3]),
    .s   (sel[3:2]),
    .out (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y;
      sel_q <= sel;
      vld_q <= 1'b1;
    end
  end

`ifdef MUX16_ONEHOT_SEL_EN
  // Decoded from the registered select so it stays aligned with y_q.
  always_comb begin
    sel_oh = '0;
    if (vld_q) sel_oh[sel_q] = 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux16x1_struct.sv
module tb_mux16x1_struct;

  logic        clk;
  logic        rst;
  logic [15:0] in1;
  logic [3:0]  sel1;
  logic        y1, y1_q, vld1_q;
  logic [3:0]  sel1_q;
  logic [127:0] in8;
  logic [3:0]  sel8;
  logic [7:0]  y8, y8_q;
  logic [3:0]  sel8_q;
  logic        vld8_q;
`ifdef MUX16_ONEHOT_SEL_EN
  logic [15:0] sel1_oh, sel8_oh;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  mux16x1_struct #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .in    (in1),
    .sel   (sel1),
    .y     (y1),
    .y_q   (y1_q),
    .sel_q (sel1_q),
    .vld_q (vld1_q)
`ifdef MUX16_ONEHOT_SEL_EN
    ,
    .sel_oh (sel1_oh)
`endif
  );

  mux16x1_struct #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .in    (in8),
    .sel   (sel8),
    .y     (y8),
    .y_q   (y8_q),
    .sel_q (sel8_q),
    .vld_q (vld8_q)
`ifdef MUX16_ONEHOT_SEL_EN
    ,
    .sel_oh (sel8_oh)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    in1  = 16'h5555;
    sel1 = 4'd0;
    sel8 = 4'd0;
    for (int k = 0; k < 16; k++) in8[k*8 +: 8] = 8'h10 + k[7:0];

    // Reset state
    #1;
    check("rst_y_q",   {15'b0, y1_q},   16'h0);
    check("rst_sel_q", {12'b0, sel1_q}, 16'h0);
    check("rst_vld_q", {15'b0, vld1_q}, 16'h0);
    check("rst_y8_q",  {8'b0, y8_q},    16'h0);
`ifdef MUX16_ONEHOT_SEL_EN
    check("rst_sel_oh", sel1_oh, 16'h0000);
`endif

    // Combinational sweep, alternating pattern: even lanes are 1
    in1 = 16'h5555;
    for (int s = 0; s < 16; s++) begin
      sel1 = s[3:0];
      #5;
      check("y_5555", {15'b0, y1}, (s % 2 == 0) ? 16'h1 : 16'h0);
    end

    // Only the end lanes set: 0 and 15 give 1, everything between gives 0
    in1 = 16'h8001;
    for (int s = 0; s < 16; s++) begin
      sel1 = s[3:0];
      #5;
      check("y_8001", {15'b0, y1}, (s == 0 || s == 15) ? 16'h1 : 16'h0);
    end

    // Registered stage
    @(negedge clk);
    rst  = 1'b0;
    in1  = 16'h5555;
    sel1 = 4'd3;
    @(posedge clk); #1;
    check("e1_y_q",   {15'b0, y1_q},   16'h0);
    check("e1_sel_q", {12'b0, sel1_q}, 16'h3);
    check("e1_vld_q", {15'b0, vld1_q}, 16'h1);
    sel1 = 4'd6;
    @(posedge clk); #1;
    check("e2_y_q",   {15'b0, y1_q},   16'h1);
    check("e2_sel_q", {12'b0, sel1_q}, 16'h6);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_y_q",   {15'b0, y1_q},   16'h0);
    check("arst_sel_q", {12'b0, sel1_q}, 16'h0);
    check("arst_vld_q", {15'b0, vld1_q}, 16'h0);
    sel1 = 4'd1;
    #1;
    check("arst_y_live1", {15'b0, y1}, 16'h0);
    sel1 = 4'd2;
    #1;
    check("arst_y_live2", {15'b0, y1}, 16'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_vld_q", {15'b0, vld1_q}, 16'h1);
    check("rel_sel_q", {12'b0, sel1_q}, 16'h2);
    check("rel_y_q",   {15'b0, y1_q},   16'h1);

    // sel and in change together: new lane of new data is captured
    @(negedge clk);
    sel1 = 4'd5;
    in1  = 16'h0020;
    @(posedge clk); #1;
    check("same_y_q",   {15'b0, y1_q},   16'h1);
    check("same_sel_q", {12'b0, sel1_q}, 16'h5);

`ifdef MUX16_ONEHOT_SEL_EN
    @(negedge clk);
    sel1 = 4'd9;
    @(posedge clk); #1;
    check("oh_sel9", sel1_oh, 16'h0200);
`endif

    // WIDTH=8: lane k holds 8'h10+k
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      sel8 = s[3:0];
      #1;
      check("w8_y", {8'b0, y8}, 16'h0010 + 16'(s));
      @(posedge clk); #1;
      check("w8_y_q",   {8'b0, y8_q},    16'h0010 + 16'(s));
      check("w8_sel_q", {12'b0, sel8_q}, 16'(s));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
